// File: rtl/serial_adder_n.sv
// Bit-serial adder: {cout,sum} = a + b + cin over WIDTH cycles, LSB first, with start/busy/done handshake.
// Optional signed-overflow flag 'ovf' is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_ps;
    logic [WIDTH-1:0] w_ps_nxt;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_run;
    logic [1:0]       w_ha1;
    logic [1:0]       w_ha2;
    logic             w_s;
    logic             w_carry_nxt;

    // Returns {carry, sum} of a single half-adder stage.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    assign w_run    = (r_state == S_RUN);
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Full adder from two half-adder stages.
    assign w_ha1       = half_add(r_a_sr[0], r_b_sr[0]);
    assign w_ha2       = half_add(w_ha1[0], r_carry);
    assign w_s         = w_ha2[0];
    assign w_carry_nxt = w_ha1[1] | w_ha2[1];
    assign w_ps_nxt    = (r_ps >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_run && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand shifters and running carry: only meaningful between an accepted start and DONE.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_ps    <= '0;
        end else if (w_run) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_carry <= w_carry_nxt;
            r_ps    <= w_ps_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (w_run && w_last) begin
            sum  <= w_ps_nxt;
            cout <= w_carry_nxt;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last bit r_carry is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (w_run && w_last) begin
            ovf <= r_carry ^ w_carry_nxt;
        end
    end
`endif

endmodule
